// File: rtl/wired_fullbuffer.sv
// Two-entry valid/ready register slice: every output (valid, payload, ready, occupancy) comes from a flop.
// Optional synchronous discard port enabled by defining WIRED_FULLBUFFER_FLUSH_EN.
module wired_fullbuffer #(
  parameter int  DATA_WIDTH = 32,
  parameter type T          = logic [DATA_WIDTH-1:0]
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inport_valid,
  output logic       inport_ready,
  input  T           inport_payload,
  output logic       outport_valid,
  input  logic       outport_ready,
  output T           outport_payload,
  output logic [1:0] occupancy
`ifdef WIRED_FULLBUFFER_FLUSH_EN
  ,
  input  logic       flush
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  T           head;
  T           skid;
  logic       in_rdy;
  logic       out_vld;
  logic       in_fire;
  logic       out_fire;
  logic       head_from_in;
  logic       head_from_skid;
  logic       skid_from_in;

  assign in_fire  = inport_valid & in_rdy;
  assign out_fire = out_vld & outport_ready;

  always_comb begin
    state_nxt      = state;
    head_from_in   = 1'b0;
    head_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          head_from_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          head_from_in = 1'b1;
        end else if (in_fire) begin
          skid_from_in = 1'b1;
          state_nxt    = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          head_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
`ifdef WIRED_FULLBUFFER_FLUSH_EN
    // Flush overrides everything: the accepted word is dropped, a delivered word stays delivered.
    if (flush) begin
      state_nxt      = EMPTY;
      head_from_in   = 1'b0;
      head_from_skid = 1'b0;
      skid_from_in   = 1'b0;
    end
`endif
  end

  // Control: ready/valid are recomputed from the next state so they leave flops directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      in_rdy  <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      in_rdy  <= (state_nxt != FULL);
      out_vld <= (state_nxt != EMPTY);
    end
  end

  // Data: written only on the transfer events decoded above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (head_from_in) begin
        head <= inport_payload;
      end else if (head_from_skid) begin
        head <= skid;
      end
      if (skid_from_in) begin
        skid <= inport_payload;
      end
    end
  end

  assign inport_ready    = in_rdy;
  assign outport_valid   = out_vld;
  assign outport_payload = head;
  assign occupancy       = state;

endmodule

// File: tb/tb_wired_fullbuffer.sv
// Directed table vectors plus reset, streaming, flush and randomized scoreboard sequences for wired_fullbuffer.
`timescale 1ns/1ps
module tb_wired_fullbuffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inport_valid = 1'b0;
  logic        inport_ready;
  logic [31:0] inport_payload = '0;
  logic        outport_valid;
  logic        outport_ready = 1'b0;
  logic [31:0] outport_payload;
  logic [1:0]  occupancy;
  logic        flush = 1'b0;

  int tests    = 0;
  int failures = 0;
  int stab_viol = 0;
  int bad_state = 0;

  wired_fullbuffer #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .inport_valid    (inport_valid),
    .inport_ready    (inport_ready),
    .inport_payload  (inport_payload),
    .outport_valid   (outport_valid),
    .outport_ready   (outport_ready),
    .outport_payload (outport_payload),
    .occupancy       (occupancy)
`ifdef WIRED_FULLBUFFER_FLUSH_EN
    ,
    .flush           (flush)
`endif
  );

  always #5 clk = ~clk;

  // Output-stability and illegal-occupancy monitor.
  always @(posedge clk) begin
    logic        hold_pre;
    logic [31:0] held;
    hold_pre = outport_valid & ~outport_ready & ~rst;
    held     = outport_payload;
    #1;
    if (hold_pre && !rst && (!outport_valid || outport_payload !== held)) stab_viol++;
    if (occupancy == 2'd3) bad_state++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    inport_valid   = iv;
    inport_payload = d;
    outport_ready  = ordy;
    flush          = fl;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_p;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] sent_q[$];
    logic [31:0] exp_w;
    int sent, rcvd, sb_err, cycles;
    logic in_f, out_f;

    vecs[0]  = '{1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 32'hA, 2'd1};
    vecs[1]  = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2};
    vecs[2]  = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2};
    vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2};
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hB, 2'd1};
    vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hB, 2'd0};
    vecs[6]  = '{1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 32'h5, 2'd1};
    vecs[7]  = '{1'b1, 32'h6, 1'b1, 1'b1, 1'b1, 32'h6, 2'd1};
    vecs[8]  = '{1'b0, 32'h7, 1'b0, 1'b1, 1'b1, 32'h6, 2'd1};
    vecs[9]  = '{1'b1, 32'h8, 1'b1, 1'b1, 1'b1, 32'h8, 2'd1};
    vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h8, 2'd0};
    vecs[11] = '{1'b0, 32'h9, 1'b1, 1'b1, 1'b0, 32'h8, 2'd0};

    // Power-on reset, released away from a clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_ov",   {31'd0, outport_valid}, 32'd0);
    check("rst_rdy",  {31'd0, inport_ready}, 32'd0);
    check("rst_occ",  {30'd0, occupancy}, 32'd0);
    check("rst_data", outport_payload, 32'd0);
    #19 rst = 1'b0;
    #1;
    check("rel_rdy_low", {31'd0, inport_ready}, 32'd0);
    @(posedge clk); #1;
    check("rel_rdy_high", {31'd0, inport_ready}, 32'd1);

    // Directed table: backpressure, drain, simultaneous in/out, idle payload hold.
    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
      check($sformatf("vec%0d_rdy", i), {31'd0, inport_ready}, {31'd0, vecs[i].e_rdy});
      check($sformatf("vec%0d_ov", i),  {31'd0, outport_valid}, {31'd0, vecs[i].e_ov});
      check($sformatf("vec%0d_p", i),   outport_payload, vecs[i].e_p);
      check($sformatf("vec%0d_occ", i), {30'd0, occupancy}, {30'd0, vecs[i].e_occ});
    end

    // Streaming 0x1..0x10 with downstream always ready.
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 32'(k), 1'b1, 1'b0);
      check($sformatf("str%0d_p", k),   outport_payload, 32'(k));
      check($sformatf("str%0d_occ", k), {30'd0, occupancy}, 32'd1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("str_drain_occ", {30'd0, occupancy}, 32'd0);

    // Reset in the middle of a full buffer.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    check("mid_full_occ", {30'd0, occupancy}, 32'd2);
    @(negedge clk);
    inport_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ov",  {31'd0, outport_valid}, 32'd0);
    check("mid_rst_rdy", {31'd0, inport_ready}, 32'd0);
    check("mid_rst_occ", {30'd0, occupancy}, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("mid_rel_rdy_low", {31'd0, inport_ready}, 32'd0);
    @(posedge clk); #1;
    check("mid_rel_rdy_high", {31'd0, inport_ready}, 32'd1);
    check("mid_rel_occ", {30'd0, occupancy}, 32'd0);

`ifdef WIRED_FULLBUFFER_FLUSH_EN
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b0);
    check("fl_full_occ", {30'd0, occupancy}, 32'd2);
    step(1'b1, 32'h3, 1'b0, 1'b1);
    check("fl_occ", {30'd0, occupancy}, 32'd0);
    check("fl_ov",  {31'd0, outport_valid}, 32'd0);
    check("fl_rdy", {31'd0, inport_ready}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("fl_no3_ov", {31'd0, outport_valid}, 32'd0);
    step(1'b1, 32'h4, 1'b0, 1'b0);
    step(1'b1, 32'h5, 1'b1, 1'b1);
    check("fl_one_occ", {30'd0, occupancy}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("fl_no5_ov", {31'd0, outport_valid}, 32'd0);
`endif

    // Random 50% valid / 30% ready traffic against a queue scoreboard.
    sent = 0; rcvd = 0; sb_err = 0; cycles = 0;
    while (rcvd < 10000 && cycles < 80000) begin
      @(negedge clk);
      inport_valid   = (sent < 10000) && ($urandom_range(99) < 50);
      inport_payload = $urandom;
      outport_ready  = ($urandom_range(99) < 30);
      flush          = 1'b0;
      #1;
      in_f  = inport_valid & inport_ready;
      out_f = outport_valid & outport_ready;
      if (out_f) begin
        if (sent_q.size() == 0) begin
          sb_err++;
        end else begin
          exp_w = sent_q.pop_front();
          if (outport_payload !== exp_w) sb_err++;
        end
        rcvd++;
      end
      if (in_f) begin
        sent_q.push_back(inport_payload);
        sent++;
      end
      @(posedge clk);
      cycles++;
    end
    check("rand_rcvd", 32'(rcvd), 32'd10000);
    check("rand_order_err", 32'(sb_err), 32'd0);
    check("rand_leftover", 32'(sent_q.size()), 32'd0);
    @(negedge clk);
    inport_valid  = 1'b0;
    outport_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("stability_viol", 32'(stab_viol), 32'd0);
    check("state3_seen", 32'(bad_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
